// File: rtl/maxpool2x2_128channel_layer6_pkg.sv
// Shared constants for the layer-6 2x2 max-pool: fp32 encoding details, pooling geometry, channel count.
package maxpool2x2_128channel_layer6_pkg;

  localparam logic [31:0] FP32_POS_ZERO = 32'h0000_0000;
  localparam int          SIGN_BIT      = 31;

  localparam int POOL_WIN    = 2;
  localparam int POOL_STRIDE = 2;

  localparam int CHANNEL_DEF = 128;

endpackage

// File: rtl/maxpool2x2_128channel_layer6_fp32_max.sv
// Combinational fp32 max using a sign-magnitude compare; +0 beats -0, ties keep operand a.
// Zero latency; no flow control.
module fp32_max
  import maxpool2x2_128channel_layer6_pkg::*;
#(
  parameter int DATA_WIDHT = 32
) (
  input  logic [DATA_WIDHT-1:0] i_a,
  input  logic [DATA_WIDHT-1:0] i_b,
  output logic [DATA_WIDHT-1:0] o_max
);

  logic w_sign_a;
  logic w_sign_b;
  logic w_mag_b_gt;
  logic w_mag_b_lt;
  logic w_b_wins;

  assign w_sign_a   = i_a[SIGN_BIT];
  assign w_sign_b   = i_b[SIGN_BIT];
  assign w_mag_b_gt = i_b[SIGN_BIT-1:0] > i_a[SIGN_BIT-1:0];
  assign w_mag_b_lt = i_b[SIGN_BIT-1:0] < i_a[SIGN_BIT-1:0];

  // b replaces a only when strictly greater; a negative a always loses to a positive b (covers -0 vs +0)
  always_comb begin
    w_b_wins = 1'b0;
    case ({w_sign_a, w_sign_b})
      2'b00:   w_b_wins = w_mag_b_gt;
      2'b11:   w_b_wins = w_mag_b_lt;
      2'b10:   w_b_wins = 1'b1;
      default: w_b_wins = 1'b0;
    endcase
  end

  assign o_max = w_b_wins ? i_b : i_a;

endmodule

// File: rtl/maxpool2x2_128channel_layer6.sv
// 2x2/stride-2 fp32 max-pool over a raster pixel stream; 1-cycle latency from the (odd row, odd col) beat.
// No backpressure: Valid_In gaps freeze state. Optional fused ReLU via MAXPOOL_FUSED_RELU_EN.
module maxpool2x2_128channel_layer6
  import maxpool2x2_128channel_layer6_pkg::*;
#(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNEL    = CHANNEL_DEF,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDHT*CHANNEL-1:0] Data_In,
  input  logic                          Valid_In,
  output logic [DATA_WIDHT*CHANNEL-1:0] Data_Out,
  output logic                          Valid_Out,
  output logic                          Frame_Done
);

  localparam int PIX_W    = DATA_WIDHT * CHANNEL;
  localparam int CW       = (IMG_WIDHT > 1) ? $clog2(IMG_WIDHT) : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDHT / POOL_STRIDE;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  // Odd dimensions drop the trailing column/row, so the last window ends on the last odd index.
  localparam int LAST_COL = (IMG_WIDHT / POOL_WIN) * POOL_WIN - 1;
  localparam int LAST_ROW = (IMG_HEIGHT / POOL_WIN) * POOL_WIN - 1;

  logic [CW-1:0]    r_col_cnt;
  logic [RW-1:0]    r_row_cnt;
  logic [PIX_W-1:0] r_hold;
  logic [PIX_W-1:0] r_line_buf [LB_DEPTH];

  logic             w_col_last;
  logic             w_row_last;
  logic             w_col_odd;
  logic             w_row_odd;
  logic             w_lb_wr;
  logic             w_emit;
  logic             w_at_last;
  logic [LBW-1:0]   w_lb_idx;
  logic [PIX_W-1:0] w_lb_rd;
  logic [PIX_W-1:0] w_hmax;
  logic [PIX_W-1:0] w_vmax;
  logic [PIX_W-1:0] w_pool;

  assign w_col_last = (r_col_cnt == CW'(IMG_WIDHT - 1));
  assign w_row_last = (r_row_cnt == RW'(IMG_HEIGHT - 1));
  assign w_col_odd  = r_col_cnt[0];
  assign w_row_odd  = r_row_cnt[0];
  assign w_lb_wr    = Valid_In & ~w_row_odd & w_col_odd;
  assign w_emit     = Valid_In & w_row_odd & w_col_odd;
  assign w_at_last  = (r_row_cnt == RW'(LAST_ROW)) && (r_col_cnt == CW'(LAST_COL));
  assign w_lb_idx   = LBW'(r_col_cnt >> 1);
  assign w_lb_rd    = r_line_buf[w_lb_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_hold    <= '0;
    end else if (Valid_In) begin
      if (w_col_last) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_row_last ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
      if (!w_col_odd) begin
        r_hold <= Data_In;
      end
    end
  end

  // Not reset: every entry is written on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (w_lb_wr) begin
      r_line_buf[w_lb_idx] <= w_hmax;
    end
  end

  for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
    fp32_max #(
      .DATA_WIDHT(DATA_WIDHT)
    ) u_hmax (
      .i_a  (r_hold[k*DATA_WIDHT +: DATA_WIDHT]),
      .i_b  (Data_In[k*DATA_WIDHT +: DATA_WIDHT]),
      .o_max(w_hmax[k*DATA_WIDHT +: DATA_WIDHT])
    );

    fp32_max #(
      .DATA_WIDHT(DATA_WIDHT)
    ) u_vmax (
      .i_a  (w_lb_rd[k*DATA_WIDHT +: DATA_WIDHT]),
      .i_b  (w_hmax[k*DATA_WIDHT +: DATA_WIDHT]),
      .o_max(w_vmax[k*DATA_WIDHT +: DATA_WIDHT])
    );

`ifdef MAXPOOL_FUSED_RELU_EN
    assign w_pool[k*DATA_WIDHT +: DATA_WIDHT] = w_vmax[k*DATA_WIDHT + SIGN_BIT] ?
        DATA_WIDHT'(FP32_POS_ZERO) : w_vmax[k*DATA_WIDHT +: DATA_WIDHT];
`else
    assign w_pool[k*DATA_WIDHT +: DATA_WIDHT] = w_vmax[k*DATA_WIDHT +: DATA_WIDHT];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Data_Out   <= {CHANNEL{DATA_WIDHT'(FP32_POS_ZERO)}};
      Valid_Out  <= 1'b0;
      Frame_Done <= 1'b0;
    end else begin
      Valid_Out  <= w_emit;
      Frame_Done <= w_emit & w_at_last;
      if (w_emit) begin
        Data_Out <= w_pool;
      end
    end
  end

endmodule

// File: tb/tb_maxpool2x2_128channel_layer6.sv
// Directed + randomized bench for the 2x2 max-pool on a 4x4 image; expectations come from a real-valued window model.
`timescale 1ns/1ps
module tb_maxpool2x2_128channel_layer6;
  localparam int DW = 32;
  localparam int CH = 128;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = DW * CH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] Data_In = '0;
  logic          Valid_In = 1'b0;
  logic [PW-1:0] Data_Out;
  logic          Valid_Out;
  logic          Frame_Done;

  maxpool2x2_128channel_layer6 #(
    .DATA_WIDHT(DW), .CHANNEL(CH), .IMG_WIDHT(W), .IMG_HEIGHT(H)
  ) dut (
    .clk(clk), .rst(rst), .Data_In(Data_In), .Valid_In(Valid_In),
    .Data_Out(Data_Out), .Valid_Out(Valid_Out), .Frame_Done(Frame_Done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int stray_fd = 0;
  int hold_err = 0;
  logic [PW-1:0] last_out = '0;
  logic [PW-1:0] img [W*H];
  logic [PW-1:0] exp_dat[$];
  logic [PW-1:0] got_dat[$];
  bit            exp_fd[$];
  bit            got_fd[$];
  int            exp_cyc[$];
  int            got_cyc[$];

  function automatic real fp2r(input logic [31:0] v);
    real mag;
    int  e;
    e = int'(v[30:23]);
    if (e == 0) mag = real'(v[22:0]) * (2.0 ** (-149));
    else        mag = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -mag : mag;
  endfunction

  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    real ra, rb;
    ra = fp2r(a);
    rb = fp2r(b);
    if (rb > ra) return b;
    if (ra > rb) return a;
    if (ra == 0.0) return (a[31] && b[31]) ? a : 32'h0;
    return a;
  endfunction

  function automatic logic [31:0] int2fp(input int n);
    int p;
    logic [31:0] t;
    if (n == 0) return 32'h0;
    p = 0;
    while ((n >> (p + 1)) != 0) p++;
    t = 32'(n) << (23 - p);
    return {1'b0, 8'(127 + p), t[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0: v = 32'h0000_0000;
      1: v = 32'h8000_0000;
      2: v = {$urandom_range(0, 1) == 1, 8'd127, 23'($urandom_range(0, 3))};
      default: v = {$urandom_range(0, 1) == 1, 8'($urandom_range(0, 254)), 23'($urandom)};
    endcase
    return v;
  endfunction

  function automatic logic [PW-1:0] window(input int r0, input int c0);
    logic [PW-1:0] o;
    logic [31:0]   m;
    for (int ch = 0; ch < CH; ch++) begin
      m = img[r0*W + c0][ch*DW +: DW];
      for (int d = 1; d < 4; d++)
        m = ref_max(m, img[(r0 + d/2)*W + c0 + d%2][ch*DW +: DW]);
`ifdef MAXPOOL_FUSED_RELU_EN
      if (m[31]) m = 32'h0;
`endif
      o[ch*DW +: DW] = m;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, expv);
  endtask

  task automatic chkpix(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] expv);
    int k;
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      k = 0;
      while (k < CH - 1 && obs[k*DW +: DW] === expv[k*DW +: DW]) k++;
      $error("FAIL %s: ch%0d got %h expected %h", tag, k, obs[k*DW +: DW], expv[k*DW +: DW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (Valid_Out) begin
      got_dat.push_back(Data_Out);
      got_fd.push_back(Frame_Done);
      got_cyc.push_back(cyc);
      last_out = Data_Out;
    end else begin
      if (Frame_Done) stray_fd++;
      if (Data_Out !== last_out) hold_err++;
    end
  endtask

  task automatic run_frame(input int gap_max);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        repeat ($urandom_range(0, gap_max)) begin
          Valid_In = 1'b0;
          Data_In  = {CH{$urandom}};
          tick();
        end
        Valid_In = 1'b1;
        Data_In  = img[r*W + c];
        tick();
        if (r % 2 == 1 && c % 2 == 1) begin
          exp_dat.push_back(window(r - 1, c - 1));
          exp_fd.push_back(r == H - 1 && c == W - 1);
          exp_cyc.push_back(cyc);
        end
      end
    end
    Valid_In = 1'b0;
  endtask

  task automatic compare_clear(input string tag);
    chk($sformatf("%s_count", tag), 32'(got_dat.size()), 32'(exp_dat.size()));
    for (int i = 0; i < exp_dat.size() && i < got_dat.size(); i++) begin
      chkpix($sformatf("%s_data%0d", tag, i), got_dat[i], exp_dat[i]);
      chk($sformatf("%s_fd%0d", tag, i), 32'(got_fd[i]), 32'(exp_fd[i]));
      chk($sformatf("%s_lat%0d", tag, i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
    end
    got_dat.delete(); got_fd.delete(); got_cyc.delete();
    exp_dat.delete(); exp_fd.delete(); exp_cyc.delete();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < W*H; i++) img[i] = {CH{int2fp(i)}};
  endtask

  task automatic set_random();
    for (int i = 0; i < W*H; i++)
      for (int ch = 0; ch < CH; ch++) img[i][ch*DW +: DW] = rnd_fp();
  endtask

  initial begin
    int nfd;
    #1;
    chk("rst_valid", 32'(Valid_Out), 32'h0);
    chk("rst_fd", 32'(Frame_Done), 32'h0);
    chkpix("rst_data", Data_Out, '0);
    tick(); tick();
    rst = 1'b1;

    set_ramp();
    run_frame(0);
    repeat (3) tick();
    chk("ramp_first", got_dat[0][31:0], 32'h40A0_0000);
    chk("ramp_last", got_dat[3][31:0], 32'h4170_0000);
    compare_clear("ramp");

    run_frame(5);
    repeat (3) tick();
    compare_clear("ramp_gaps");

    set_random();
    img[0] = {CH{32'hBF80_0000}};
    img[1] = {CH{32'hC000_0000}};
    img[W] = {CH{32'hC040_0000}};
    img[W+1] = {CH{32'hC080_0000}};
    run_frame(0);
    repeat (3) tick();
`ifdef MAXPOOL_FUSED_RELU_EN
    chk("neg_win", got_dat[0][31:0], 32'h0000_0000);
`else
    chk("neg_win", got_dat[0][31:0], 32'hBF80_0000);
`endif
    compare_clear("neg");

    for (int i = 0; i < W*H; i++) img[i] = '0;
    for (int r = 1; r < H; r += 2)
      for (int c = 1; c < W; c += 2)
        for (int ch = 0; ch < CH; ch++) img[r*W + c][ch*DW +: DW] = int2fp(ch);
    run_frame(2);
    repeat (3) tick();
    chk("perch_127", got_dat[0][127*DW +: DW], 32'h42FE_0000);
    compare_clear("perch");

    for (int f = 0; f < 3; f++) begin
      set_random();
      run_frame(3);
      repeat (3) tick();
      compare_clear($sformatf("rand%0d", f));
    end

    set_ramp();
    for (int i = 0; i < 6; i++) begin
      Valid_In = 1'b1;
      Data_In  = img[i];
      tick();
    end
    Valid_In = 1'b0;
    tick();
    got_dat.delete(); got_fd.delete(); got_cyc.delete();
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(Valid_Out), 32'h0);
    chkpix("midrst_data", Data_Out, '0);
    last_out = '0;
    repeat (3) begin
      Valid_In = 1'b1;
      Data_In  = {CH{$urandom}};
      tick();
    end
    Valid_In = 1'b0;
    chk("midrst_quiet", 32'(got_dat.size()), 32'h0);
    rst = 1'b1;
    run_frame(0);
    repeat (3) tick();
    compare_clear("fresh");

    set_random();
    run_frame(0);
    run_frame(0);
    repeat (3) tick();
    nfd = 0;
    foreach (got_fd[i]) nfd += int'(got_fd[i]);
    chk("b2b_fd_count", 32'(nfd), 32'd2);
    compare_clear("b2b");

    chk("stray_fd", 32'(stray_fd), 32'h0);
    chk("hold_data", 32'(hold_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
